// File: rtl/pdp8_ext_ram_arb.sv
// PDP-8 data-break arbiter: slots I/O-side memory requests into
// free CPU memory cycles on a shared RAM port, CPU always first.
module pdp8_ext_ram_arb #(
  parameter int WAIT_LIMIT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] cpu_ram_addr,
  input  logic [11:0] cpu_ram_data_in,
  input  logic        cpu_ram_rd,
  input  logic        cpu_ram_wr,
  output logic [11:0] cpu_ram_data_out,
  input  logic        ext_ram_read_req,
  input  logic        ext_ram_write_req,
  input  logic [14:0] ext_ram_ma,
  input  logic [11:0] ext_ram_in,
  output logic [11:0] ext_ram_out,
  output logic        ext_ram_done,
  output logic [14:0] ram_addr,
  output logic [11:0] ram_data_in,
  output logic        ram_rd,
  output logic        ram_wr,
  input  logic [11:0] ram_data_out,
  output logic        ext_ram_busy,
  output logic        ext_ram_stalled
);

  localparam int CW =
    (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  typedef enum logic [2:0] {
    IDLE, ARM, ACC, DONE, DROP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [14:0]   ma_q;
  logic [11:0]   din_q;
  logic          wr_q;
  logic [CW-1:0] blk_q;
  logic          req;
  logic          free;
  logic          take;

  assign req  = ext_ram_read_req | ext_ram_write_req;
  assign free = !cpu_ram_rd && !cpu_ram_wr;
  // reset keeps the port on the CPU even if we were mid-ARM
  assign take = (state == ARM) && free && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req) state_nx = ARM;
      ARM:     if (free) state_nx = ACC;
      ACC:     state_nx = DONE;
      DONE:    state_nx = DROP;
      DROP:    if (!req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ma_q        <= '0;
      din_q       <= '0;
      wr_q        <= 1'b0;
      blk_q       <= '0;
      ext_ram_out <= '0;
    end else begin
      if (state == IDLE && req) begin
        ma_q  <= ext_ram_ma;
        din_q <= ext_ram_in;
        wr_q  <= ext_ram_write_req;
      end
      if (state == ARM && !free) begin
        if (blk_q != LIMIT) blk_q <= blk_q + CW'(1);
      end else begin
        blk_q <= '0;
      end
      if (state == ACC && !wr_q) ext_ram_out <= ram_data_out;
    end
  end

  assign ram_addr    = take ? ma_q  : cpu_ram_addr;
  assign ram_data_in = take ? din_q : cpu_ram_data_in;
  assign ram_rd      = take ? !wr_q : cpu_ram_rd;
  assign ram_wr      = take ? wr_q  : cpu_ram_wr;

  assign cpu_ram_data_out = ram_data_out;

  assign ext_ram_done    = (state == DONE) && !reset;
  assign ext_ram_busy    = (state == ARM || state == ACC) && !reset;
  assign ext_ram_stalled = (blk_q == LIMIT) && !reset;

endmodule

// File: tb/tb_pdp8_ext_ram_arb.sv
// Bench for pdp8_ext_ram_arb: directed scenarios plus randomized
// transactions against a timing/memory reference model.
module tb_pdp8_ext_ram_arb;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] cpu_ram_addr;
  logic [11:0] cpu_ram_data_in;
  logic        cpu_ram_rd;
  logic        cpu_ram_wr;
  logic [11:0] cpu_ram_data_out;
  logic        ext_ram_read_req;
  logic        ext_ram_write_req;
  logic [14:0] ext_ram_ma;
  logic [11:0] ext_ram_in;
  logic [11:0] ext_ram_out;
  logic        ext_ram_done;
  logic [14:0] ram_addr;
  logic [11:0] ram_data_in;
  logic        ram_rd;
  logic        ram_wr;
  logic [11:0] ram_data_out;
  logic        ext_ram_busy;
  logic        ext_ram_stalled;

  logic [11:0] mem [0:32767];
  logic [11:0] ref_mem [0:32767];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [11:0] exp_out;

  pdp8_ext_ram_arb #(.WAIT_LIMIT(WL)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_ram_addr(cpu_ram_addr),
    .cpu_ram_data_in(cpu_ram_data_in),
    .cpu_ram_rd(cpu_ram_rd),
    .cpu_ram_wr(cpu_ram_wr),
    .cpu_ram_data_out(cpu_ram_data_out),
    .ext_ram_read_req(ext_ram_read_req),
    .ext_ram_write_req(ext_ram_write_req),
    .ext_ram_ma(ext_ram_ma),
    .ext_ram_in(ext_ram_in),
    .ext_ram_out(ext_ram_out),
    .ext_ram_done(ext_ram_done),
    .ram_addr(ram_addr),
    .ram_data_in(ram_data_in),
    .ram_rd(ram_rd),
    .ram_wr(ram_wr),
    .ram_data_out(ram_data_out),
    .ext_ram_busy(ext_ram_busy),
    .ext_ram_stalled(ext_ram_stalled)
  );

  always #5 clk = ~clk;

  // synchronous RAM behind the shared port
  initial begin
    ram_data_out = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 12'(i * 7 + 3);
    mem[15'o200] = 12'o7402;
    mem[15'o5]   = 12'o4321;
    forever begin
      @(posedge clk);
      if (ram_wr) mem[ram_addr] <= ram_data_in;
      if (ram_rd) ram_data_out <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_ram_addr      = '0;
    cpu_ram_data_in   = '0;
    cpu_ram_rd        = 1'b0;
    cpu_ram_wr        = 1'b0;
    ext_ram_read_req  = 1'b0;
    ext_ram_write_req = 1'b0;
    ext_ram_ma        = '0;
    ext_ram_in        = '0;
  endtask

  task automatic test_reset();
    idle_in();
    reset        = 1'b1;
    cpu_ram_rd   = 1'b1;
    cpu_ram_addr = 15'o123;
    tick();
    tick();
    n_tests++;
    if (ram_rd !== 1'b1 || ram_addr !== 15'o123) begin
      n_fail++;
      $display("FAIL reset_pass rd=%b addr=%o want 1 123",
               ram_rd, ram_addr);
    end
    reset      = 1'b0;
    cpu_ram_rd = 1'b0;
    tick();
    n_tests++;
    if ({ext_ram_busy, ext_ram_done, ext_ram_stalled} !== 3'b000
        || ext_ram_out !== 12'o0) begin
      n_fail++;
      $display("FAIL reset_vals bds=%b%b%b out=%o want 000 0",
               ext_ram_busy, ext_ram_done, ext_ram_stalled,
               ext_ram_out);
    end
    exp_out = '0;
  endtask

  task automatic test_read_basic();
    int done_at;
    int rd_n;
    done_at = -1;
    rd_n    = 0;
    ext_ram_ma = 15'o200;
    for (int c = 0; c < 8; c++) begin
      ext_ram_read_req = (c < 4);
      #1;
      if (ram_rd) rd_n++;
      if (ext_ram_done && done_at < 0) done_at = c;
      tick();
    end
    n_tests++;
    if (done_at != 3 || rd_n != 1 || ext_ram_out !== 12'o7402) begin
      n_fail++;
      $display("FAIL rd_basic done=%0d rds=%0d out=%o want 3 1 7402",
               done_at, rd_n, ext_ram_out);
    end
    exp_out = 12'o7402;
  endtask

  task automatic test_write_basic();
    int wr_n;
    int good_n;
    int done_n;
    wr_n = 0; good_n = 0; done_n = 0;
    ext_ram_ma = 15'o10017;
    ext_ram_in = 12'o1234;
    for (int c = 0; c < 8; c++) begin
      ext_ram_write_req = (c < 4);
      #1;
      if (ram_wr) wr_n++;
      if (ram_wr && ram_addr === 15'o10017
          && ram_data_in === 12'o1234) good_n++;
      if (ext_ram_done) done_n++;
      tick();
    end
    n_tests++;
    if (wr_n != 1 || good_n != 1 || done_n != 1) begin
      n_fail++;
      $display("FAIL wr_basic wrs=%0d good=%0d dones=%0d want 1 1 1",
               wr_n, good_n, done_n);
    end
    ref_mem[15'o10017] = 12'o1234;
    cpu_ram_rd   = 1'b1;
    cpu_ram_addr = 15'o10017;
    tick();
    cpu_ram_rd = 1'b0;
    #1;
    n_tests++;
    if (cpu_ram_data_out !== 12'o1234 || ext_ram_out !== exp_out) begin
      n_fail++;
      $display("FAIL wr_readback cpu=%o out=%o want 1234 %o",
               cpu_ram_data_out, ext_ram_out, exp_out);
    end
  endtask

  task automatic test_cpu_block();
    int bad;
    int acc_ok;
    int done_at;
    bad = 0; acc_ok = 0; done_at = -1;
    ext_ram_ma   = 15'o5;
    cpu_ram_addr = 15'o777;
    for (int c = 0; c < 16; c++) begin
      ext_ram_read_req = (c < 14);
      cpu_ram_rd = (c >= 1 && c <= 10);
      #1;
      if (c >= 1 && c <= 10 && (ram_addr !== 15'o777
          || ram_rd !== 1'b1 || ram_wr !== 1'b0)) bad++;
      if ((c >= 1 && c <= 12) && ext_ram_busy !== 1'b1) bad++;
      if (c == 11 && ram_rd && !ram_wr
          && ram_addr === 15'o5) acc_ok = 1;
      if (ext_ram_done && done_at < 0) done_at = c;
      tick();
    end
    n_tests++;
    if (bad != 0 || acc_ok != 1 || done_at != 13
        || ext_ram_out !== 12'o4321) begin
      n_fail++;
      $display("FAIL cpu_block bad=%0d acc=%0d done=%0d out=%o",
               bad, acc_ok, done_at, ext_ram_out);
    end
    exp_out = 12'o4321;
  endtask

  task automatic test_stall();
    int rise_at;
    int st_acc;
    rise_at = -1; st_acc = -1;
    ext_ram_ma      = 15'o6;
    ext_ram_in      = 12'o55;
    cpu_ram_addr    = 15'o700;
    cpu_ram_data_in = 12'o11;
    for (int c = 0; c < 12; c++) begin
      ext_ram_write_req = (c < 10);
      cpu_ram_wr = (c >= 1 && c <= 6);
      #1;
      if (ext_ram_stalled && rise_at < 0) rise_at = c;
      if (c == 8) st_acc = int'(ext_ram_stalled);
      tick();
    end
    ref_mem[15'o700] = 12'o11;
    ref_mem[15'o6]   = 12'o55;
    n_tests++;
    if (rise_at != 5 || st_acc != 0) begin
      n_fail++;
      $display("FAIL stall rise=%0d acc_st=%0d want 5 0",
               rise_at, st_acc);
    end
  endtask

  task automatic test_both_held();
    int wr_n;
    int rd_n;
    int done_n;
    int done_at;
    wr_n = 0; rd_n = 0; done_n = 0; done_at = -1;
    ext_ram_ma = 15'o7;
    ext_ram_in = 12'o3210;
    for (int c = 0; c < 22; c++) begin
      ext_ram_read_req  = (c < 20);
      ext_ram_write_req = (c < 20);
      #1;
      if (ram_wr && ram_addr === 15'o7) wr_n++;
      if (ram_rd) rd_n++;
      if (ext_ram_done) done_n++;
      tick();
    end
    ref_mem[15'o7] = 12'o3210;
    n_tests++;
    if (wr_n != 1 || rd_n != 0 || done_n != 1) begin
      n_fail++;
      $display("FAIL both_held wrs=%0d rds=%0d dones=%0d want 1 0 1",
               wr_n, rd_n, done_n);
    end
    for (int c = 0; c < 6; c++) begin
      ext_ram_read_req = (c < 4);
      #1;
      if (ext_ram_done && done_at < 0) done_at = c;
      tick();
    end
    exp_out = 12'o3210;
    n_tests++;
    if (done_at != 3 || ext_ram_out !== exp_out) begin
      n_fail++;
      $display("FAIL both_rearm done=%0d out=%o want 3 %o",
               done_at, ext_ram_out, exp_out);
    end
  endtask

  task automatic test_reset_mid();
    int done_n;
    done_n = 0;
    ext_ram_ma       = 15'o10;
    ext_ram_read_req = 1'b1;
    tick();
    reset            = 1'b1;
    ext_ram_read_req = 1'b0;
    #1;
    n_tests++;
    if (ram_rd !== 1'b0 || ram_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_port rd=%b wr=%b want 0 0",
               ram_rd, ram_wr);
    end
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({ext_ram_busy, ext_ram_done, ext_ram_stalled} !== 3'b000
        || ext_ram_out !== 12'o0) begin
      n_fail++;
      $display("FAIL rst_mid_vals bds=%b%b%b out=%o want 000 0",
               ext_ram_busy, ext_ram_done, ext_ram_stalled,
               ext_ram_out);
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      if (ext_ram_done || ram_rd || ram_wr) done_n++;
      tick();
    end
    n_tests++;
    if (done_n != 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet events=%0d want 0", done_n);
    end
    exp_out = '0;
  endtask

  task automatic test_held_reset();
    int done_at;
    done_at = -1;
    ext_ram_ma       = 15'o200;
    ext_ram_read_req = 1'b1;
    reset            = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      ext_ram_read_req = (c < 4);
      #1;
      if (ext_ram_done && done_at < 0) done_at = c;
      tick();
    end
    exp_out = 12'o7402;
    n_tests++;
    if (done_at != 3 || ext_ram_out !== exp_out) begin
      n_fail++;
      $display("FAIL held_reset done=%0d out=%o want 3 7402",
               done_at, ext_ram_out);
    end
  endtask

  // Rules: access in first CPU-free cycle after acceptance,
  // done two cycles later, stall once WL blocked cycles elapsed.
  task automatic test_random();
    int          op, b, h, a, l;
    logic        wr, cpu_pend, busy_cpu;
    logic [14:0] ma;
    logic [11:0] din, cpu_exp, ext_exp;
    logic [2:0]  exp_st;
    cpu_pend = 1'b0;
    cpu_exp  = '0;
    ext_exp  = '0;
    for (int t = 0; t < 150; t++) begin
      op  = int'($urandom_range(0, 2));
      ma  = 15'($urandom_range(0, 31));
      din = 12'($urandom);
      b   = int'($urandom_range(0, 6));
      h   = int'($urandom_range(0, 3));
      a   = b + 1;
      l   = a + 3 + h;
      wr  = (op != 0);
      for (int c = 0; c <= l; c++) begin
        if (c == 0) begin
          ext_ram_read_req  = (op != 1);
          ext_ram_write_req = (op != 0);
          ext_ram_ma = ma;
          ext_ram_in = din;
        end else if (c <= a + 2) begin
          ext_ram_read_req  = 1'($urandom);
          ext_ram_write_req = 1'($urandom);
          ext_ram_ma = 15'($urandom);
          ext_ram_in = 12'($urandom);
        end else begin
          ext_ram_read_req  = (c < l);
          ext_ram_write_req = 1'b0;
        end
        if (c <= b) busy_cpu = 1'b1;
        else if (c == a) busy_cpu = 1'b0;
        else busy_cpu = ($urandom_range(0, 2) == 0);
        cpu_ram_wr      = busy_cpu && 1'($urandom);
        cpu_ram_rd      = busy_cpu && !cpu_ram_wr;
        cpu_ram_addr    = 15'($urandom_range(0, 31));
        cpu_ram_data_in = 12'($urandom);
        #1;
        n_tests++;
        if (cpu_ram_data_out !== ram_data_out
            || (cpu_pend && cpu_ram_data_out !== cpu_exp)) begin
          n_fail++;
          $display("FAIL rnd_cpu_data t=%0d c=%0d got=%o want=%o",
                   t, c, cpu_ram_data_out, cpu_exp);
        end
        cpu_pend = 1'b0;
        exp_st = {c >= 1 && c <= a + 1, c == a + 2,
                  c >= 1 && c <= a && (c - 1) >= WL};
        if (c == a + 2 && !wr) exp_out = ext_exp;
        n_tests++;
        if ({ext_ram_busy, ext_ram_done, ext_ram_stalled} !== exp_st
            || ext_ram_out !== exp_out) begin
          n_fail++;
          $display("FAIL rnd_status t=%0d c=%0d bds=%b%b%b out=%o want %b %o",
                   t, c, ext_ram_busy, ext_ram_done,
                   ext_ram_stalled, ext_ram_out, exp_st, exp_out);
        end
        n_tests++;
        if (c == a) begin
          if (ram_addr !== ma || ram_rd !== !wr || ram_wr !== wr
              || (wr && ram_data_in !== din)) begin
            n_fail++;
            $display("FAIL rnd_slot t=%0d a=%o rd=%b wr=%b d=%o want %o %b %b %o",
                     t, ram_addr, ram_rd, ram_wr, ram_data_in,
                     ma, !wr, wr, din);
          end
        end else if (ram_addr !== cpu_ram_addr
                     || ram_rd !== cpu_ram_rd
                     || ram_wr !== cpu_ram_wr
                     || ram_data_in !== cpu_ram_data_in) begin
          n_fail++;
          $display("FAIL rnd_pass t=%0d c=%0d a=%o rd=%b wr=%b want %o %b %b",
                   t, c, ram_addr, ram_rd, ram_wr,
                   cpu_ram_addr, cpu_ram_rd, cpu_ram_wr);
        end
        if (c == a) begin
          if (wr) ref_mem[ma] = din;
          else ext_exp = ref_mem[ma];
        end else if (cpu_ram_wr) begin
          ref_mem[cpu_ram_addr] = cpu_ram_data_in;
        end else if (cpu_ram_rd) begin
          cpu_exp  = ref_mem[cpu_ram_addr];
          cpu_pend = 1'b1;
        end
        tick();
      end
    end
    idle_in();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = 12'(i * 7 + 3);
    ref_mem[15'o200] = 12'o7402;
    ref_mem[15'o5]   = 12'o4321;
    exp_out = '0;
    reset   = 1'b1;
    idle_in();
    test_reset();
    test_read_basic();
    test_write_basic();
    test_cpu_block();
    test_stall();
    test_both_held();
    test_reset_mid();
    test_held_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pdp8_ext_ram_arb.md
PDP8_EXT_RAM_ARB -- requirements
Module: pdp8_ext_ram_arb

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 63: count of consecutive blocked cycles at which ext_ram_stalled asserts.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cpu_ram_addr  input  15, cpu_ram_data_in  input  12, cpu_ram_rd  input  1, cpu_ram_wr  input  1: CPU memory request.
REQ-005 SHALL have port cpu_ram_data_out  output  12: memory read data returned to the CPU.
REQ-006 SHALL have ports ext_ram_read_req  input  1, ext_ram_write_req  input  1, ext_ram_ma  input  15, ext_ram_in  input  12: I/O-side data-break request, address and write data.
REQ-007 SHALL have ports ext_ram_out  output  12 (read data) and ext_ram_done  output  1 (completion strobe).
REQ-008 SHALL have ports ram_addr  output  15, ram_data_in  output  12, ram_rd  output  1, ram_wr  output  1, ram_data_out  input  12: shared memory port.
REQ-009 SHALL have ports ext_ram_busy  output  1 (request accepted, not yet done) and ext_ram_stalled  output  1 (blocked count reached WAIT_LIMIT).

Function
REQ-010 SHALL implement FSM states IDLE, ARM, ACC, DONE, DROP.
REQ-011 In IDLE, a rising request (read_req or write_req high) SHALL latch ext_ram_ma, ext_ram_in and the op into internal registers, then enter ARM next cycle.
REQ-012 If read_req and write_req are both high at acceptance, the op SHALL be write.
REQ-013 The CPU SHALL always have priority; the block never stalls the CPU.
REQ-014 In ARM, a cycle with cpu_ram_rd=0 and cpu_ram_wr=0 is a free slot; in that cycle the ram port SHALL combinationally carry the latched address, data and op (rd or wr), and the FSM SHALL enter ACC.
REQ-015 Outside a free slot taken in ARM, the ram port SHALL pass the cpu_ram_* signals straight through.
REQ-016 cpu_ram_data_out SHALL equal ram_data_out at all times.
REQ-017 In ACC, a read SHALL capture ram_data_out into ext_ram_out; write data is committed by the memory on the ARM->ACC edge.
REQ-018 ACC SHALL go to DONE unconditionally.
REQ-019 ext_ram_done SHALL be high for exactly the one DONE cycle.
REQ-020 ext_ram_out SHALL hold its value until the next read capture.
REQ-021 DONE SHALL go to DROP; DROP SHALL return to IDLE only in a cycle where both requests are low, so a held request is served once.
REQ-022 Minimum latency (free slot at first ARM cycle), request edge to done: 3 cycles.
REQ-023 ext_ram_busy SHALL be high in ARM and ACC.
REQ-024 A blocked counter SHALL:
- increment each ARM cycle without a free slot;
- saturate at WAIT_LIMIT;
- clear on leaving ARM.
REQ-025 ext_ram_stalled SHALL be high while the blocked counter equals WAIT_LIMIT; it has no other effect.
REQ-026 Requests changing or dropping after acceptance SHALL be ignored until DROP; ma and data are used only as latched.

Reset
REQ-027 Reset SHALL force:
- FSM to IDLE;
- ext_ram_done=0, ext_ram_busy=0, ext_ram_stalled=0;
- ext_ram_out=0, blocked counter=0, latched registers=0.
REQ-028 Reset mid-operation SHALL abandon the request with no done strobe.
REQ-029 During reset the ram port SHALL pass CPU signals through.
REQ-030 A request held high across reset release SHALL be accepted as a new request.

Verification
REQ-031 CPU idle; read_req=1, ma=0o00200, mem[0o200]=0o7402 -> done pulses 3 cycles later; ext_ram_out=0o7402; ram_rd high for one cycle.
REQ-032 CPU idle; write_req=1, ma=0o10017, in=0o1234 -> one ram_wr cycle at 0o10017; done pulse; later CPU read of 0o10017 returns 0o1234.
REQ-033 cpu_ram_rd held high 10 cycles, then released, during a pending read -> ram port carries CPU signals for those 10 cycles; ext access in the first free cycle; ext_ram_busy high throughout.
REQ-034 WAIT_LIMIT=4; CPU busy 6 cycles during ARM -> ext_ram_stalled rises after 4 blocked cycles and clears when ACC is entered.
REQ-035 read_req and write_req both high, held 20 cycles -> exactly one write and one done pulse; IDLE only after both drop.
REQ-036 reset asserted in ARM -> no ram access, no done; outputs at reset values on the next cycle.
